// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encodings, ALU/funct codes and bus layouts for the MIPS execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;
    localparam int STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    // Bit positions inside the one-hot alu_op field
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MTHI = 6'h11;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MTLO = 6'h13;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1;
        logic [3:0]  src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// Decode/stall-control/MEM-facing signal bundle of the execute stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [STALL_WD-1:0]     stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
    logic                    ex_is_load;
    logic                    stallreq_for_ex;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/ex_stage_div_iter.sv
// Radix-2 restoring divider: one IDLE cycle to capture magnitudes, 32 BUSY steps, one DONE
// cycle presenting sign-corrected quotient/remainder. busy_o covers IDLE-with-start plus BUSY.
module ex_stage_div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_en_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic             a_neg, b_neg, ge;
    logic [32:0]      trial, diff;

    assign a_neg = signed_en_i & a_i[31];
    assign b_neg = signed_en_i & b_i[31];
    // trial carries the shifted-out bit; compare on full 33 bits so a zero divisor stays correct
    assign trial = {rem_q, quo_q[31]};
    assign ge    = (trial >= {1'b0, dvs_q});
    assign diff  = trial - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    busy_o  = 1'b1;
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
                    quo_d   = a_neg ? -a_i : a_i;
                    dvs_d   = b_neg ? -b_i : b_i;
                    rem_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
            DIV_BUSY: begin
                busy_o = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                quo_d  = {quo_q[30:0], ge};
                rem_d  = ge ? diff[31:0] : trial[31:0];
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                done_o  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign quot_o = qneg_q ? -quo_q : quo_q;
    assign rem_o  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: registered decode bus, inline ALU, data-SRAM request, HI/LO and divider.
// Outputs are combinational from the EX register; stallreq_for_ex holds IF..EX while dividing.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);

    id_ex_t      ex_q, ex_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        ex_adv;

    assign ex_adv = (bus.stall[2] == NO_STOP);

    always_comb begin
        ex_d = ex_q;
        if (bus.stall[2] == STOP && bus.stall[3] == NO_STOP) begin
            ex_d = '0;
        end else if (ex_adv) begin
            ex_d = bus.id_to_ex_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            ex_q <= ex_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    logic        special;
    logic [5:0]  funct;
    logic        is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic [31:0] imm_sext, imm_zext;

    assign special  = (ex_q.inst[31:26] == 6'd0);
    assign funct    = ex_q.inst[5:0];
    assign is_div   = special & (funct == FN_DIV);
    assign is_divu  = special & (funct == FN_DIVU);
    assign is_mfhi  = special & (funct == FN_MFHI);
    assign is_mflo  = special & (funct == FN_MFLO);
    assign is_mthi  = special & (funct == FN_MTHI);
    assign is_mtlo  = special & (funct == FN_MTLO);
    assign imm_sext = {{16{ex_q.inst[15]}}, ex_q.inst[15:0]};
    assign imm_zext = {16'd0, ex_q.inst[15:0]};

    logic [31:0] op_a, op_b, alu_res;

    assign op_a = ({32{ex_q.src1[0]}} & ex_q.rdata1)
                | ({32{ex_q.src1[1]}} & ex_q.pc)
                | ({32{ex_q.src1[2]}} & {27'd0, ex_q.inst[10:6]});
    assign op_b = ({32{ex_q.src2[0]}} & ex_q.rdata2)
                | ({32{ex_q.src2[1]}} & imm_sext)
                | ({32{ex_q.src2[2]}} & 32'd8)
                | ({32{ex_q.src2[3]}} & imm_zext);

    always_comb begin
        alu_res = '0;
        if (ex_q.alu_op[OP_ADD])  alu_res = alu_res | (op_a + op_b);
        if (ex_q.alu_op[OP_SUB])  alu_res = alu_res | (op_a - op_b);
        if (ex_q.alu_op[OP_SLT])  alu_res = alu_res | {31'd0, $signed(op_a) < $signed(op_b)};
        if (ex_q.alu_op[OP_SLTU]) alu_res = alu_res | {31'd0, op_a < op_b};
        if (ex_q.alu_op[OP_AND])  alu_res = alu_res | (op_a & op_b);
        if (ex_q.alu_op[OP_NOR])  alu_res = alu_res | ~(op_a | op_b);
        if (ex_q.alu_op[OP_OR])   alu_res = alu_res | (op_a | op_b);
        if (ex_q.alu_op[OP_XOR])  alu_res = alu_res | (op_a ^ op_b);
        if (ex_q.alu_op[OP_SLL])  alu_res = alu_res | (op_b << op_a[4:0]);
        if (ex_q.alu_op[OP_SRL])  alu_res = alu_res | (op_b >> op_a[4:0]);
        if (ex_q.alu_op[OP_SRA])  alu_res = alu_res | $unsigned($signed(op_b) >>> op_a[4:0]);
        if (ex_q.alu_op[OP_LUI])  alu_res = alu_res | {op_b[15:0], 16'd0};
    end

    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;

    ex_stage_div_iter u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (is_div | is_divu),
        .signed_en_i (is_div),
        .a_i         (ex_q.rdata1),
        .b_i         (ex_q.rdata2),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quot_o      (div_quot),
        .rem_o       (div_rem)
    );

    // mthi/mtlo commit only on the edge their instruction leaves EX
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quot;
        end else if (ex_adv) begin
            if (is_mthi) hi_d = ex_q.rdata1;
            if (is_mtlo) lo_d = ex_q.rdata1;
        end
    end

    logic [31:0] ex_result;
    ex_mem_t     mem_out;

    assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

    assign mem_out.pc         = ex_q.pc;
    assign mem_out.ram_en     = ex_q.ram_en;
    assign mem_out.ram_wen    = ex_q.ram_wen;
    assign mem_out.sel_rf_res = ex_q.sel_rf_res;
    assign mem_out.rf_we      = ex_q.rf_we;
    assign mem_out.rf_waddr   = ex_q.rf_waddr;
    assign mem_out.ex_result  = ex_result;

    assign bus.ex_to_mem_bus   = mem_out;
    assign bus.ex_to_id_bus    = {ex_q.rf_we, ex_q.rf_waddr, ex_result};
    assign bus.ex_is_load      = ex_q.ram_en & ~(|ex_q.ram_wen);
    assign bus.stallreq_for_ex = div_busy;
    assign bus.data_sram_en    = ex_q.ram_en;
    assign bus.data_sram_wen   = ex_q.ram_wen;
    assign bus.data_sram_addr  = ex_q.rdata1 + imm_sext;
    assign bus.data_sram_wdata = ex_q.rdata2;

    logic unused_bits;
    assign unused_bits = ^{ex_q.inst[25:16], bus.stall[5:4], bus.stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with a queue-based scoreboard and a decoupled monitor.
module tb_ex_stage;

    logic       clk;
    logic       rst;
    logic [5:0] tb_stall;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stall control model: divider request freezes IF..EX (stall[3:0]) so EX holds
    assign bus.stall = tb_stall | (bus.stallreq_for_ex ? 6'b001111 : 6'b000000);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [158:0] v;
        logic [31:0]  res;
        logic [31:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [158:0] mk(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic ren, input logic [3:0] wen,
        input logic we, input logic [4:0] wa, input logic sel,
        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2};
    endfunction

    task automatic monitor();
        exp_t        e;
        logic [31:0] last_pc;
        logic [75:0] em;
        last_pc = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && !bus.stallreq_for_ex && bus.ex_to_mem_bus[75:44] != 32'h0
                && bus.ex_to_mem_bus[75:44] != last_pc) begin
                last_pc = bus.ex_to_mem_bus[75:44];
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected pc=%h", last_pc);
                end else begin
                    e  = exp_q.pop_front();
                    em = {e.v[158:127], e.v[75], e.v[74:71], e.v[64], e.v[70], e.v[69:65], e.res};
                    chk("ex_to_mem_bus", bus.ex_to_mem_bus, em);
                    chk("ex_to_id_bus", 76'(bus.ex_to_id_bus), 76'({e.v[70], e.v[69:65], e.res}));
                    chk("sram_req", 76'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr,
                                         bus.data_sram_wdata}),
                        76'({e.v[75], e.v[74:71], e.addr, e.v[31:0]}));
                    chk("ex_is_load", 76'(bus.ex_is_load), 76'(e.v[75] & ~(|e.v[74:71])));
                end
            end
        end
    endtask

    task automatic issue(input logic [158:0] v, input logic [31:0] res, input logic [31:0] addr);
        exp_t e;
        e.v    = v;
        e.res  = res;
        e.addr = addr;
        exp_q.push_back(e);
        bus.id_to_ex_bus = v;
        @(posedge clk); #1;
        bus.id_to_ex_bus = '0;
    endtask

    task automatic div_cycles(input string nm);
        int n;
        n = 0;
        while (bus.stallreq_for_ex && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        chk(nm, 76'(n), 76'(33));
    endtask

    localparam logic [11:0] A_ADD = 12'h800, A_SLT = 12'h200, A_SLTU = 12'h100,
                            A_SLL = 12'h008, A_SRA = 12'h002, A_LUI = 12'h001;

    initial begin
        fork
            monitor();
        join_none

        rst      = 1'b1;
        tb_stall = 6'b0;
        bus.id_to_ex_bus = mk(32'h8, 32'h8C250008, A_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                              1'b1, 5'd5, 1'b1, 32'h2000, 32'h55);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_mem_bus", bus.ex_to_mem_bus, 76'd0);
        chk("rst_id_bus", 76'(bus.ex_to_id_bus), 76'd0);
        chk("rst_sram", 76'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr,
                             bus.data_sram_wdata}), 76'd0);
        chk("rst_flags", 76'({bus.ex_is_load, bus.stallreq_for_ex}), 76'd0);
        bus.id_to_ex_bus = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU / memory request vectors
        issue(mk(32'h100, 32'h00221821, A_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
                 32'd7, 32'hFFFFFFFF), 32'd6, 32'h1828);
        issue(mk(32'h104, 32'hAC22FFFC, A_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                 32'h1000, 32'hAB), 32'h0FFC, 32'h0FFC);
        issue(mk(32'h108, 32'h8C250008, A_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd5, 1'b1,
                 32'h2000, 32'h55), 32'h2008, 32'h2008);
        issue(mk(32'h10C, 32'h00022100, A_SLL, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0,
                 32'h0, 32'hF1), 32'hF10, 32'h2100);
        issue(mk(32'h110, 32'h00022203, A_SRA, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0,
                 32'h0, 32'h80000000), 32'hFF800000, 32'h2203);
        issue(mk(32'h114, 32'h3C061234, A_LUI, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0,
                 32'h0, 32'h0), 32'h12340000, 32'h1234);
        issue(mk(32'h118, 32'h0022382A, A_SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0,
                 32'hFFFFFFFF, 32'd1), 32'd1, 32'h3829);
        issue(mk(32'h11C, 32'h0022382B, A_SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0,
                 32'hFFFFFFFF, 32'd1), 32'd0, 32'h382A);
        issue(mk(32'h120, 32'h0C000000, A_ADD, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0,
                 32'h0, 32'h0), 32'h128, 32'h0);

        // HI/LO moves
        issue(mk(32'h124, 32'h00200011, 12'h0, 3'b001, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'h1234, 32'h0), 32'h0, 32'h1245);
        issue(mk(32'h128, 32'h00004010, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                 32'h0, 32'h0), 32'h1234, 32'h4010);
        issue(mk(32'h12C, 32'h00200013, 12'h0, 3'b001, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'h5678, 32'h0), 32'h0, 32'h568B);
        issue(mk(32'h130, 32'h00004812, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
                 32'h0, 32'h0), 32'h5678, 32'h4812);

        // Signed divide -7 / 2
        issue(mk(32'h140, 32'h0022001A, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'hFFFFFFF9, 32'd2), 32'h0, 32'h13);
        div_cycles("div_stall_cycles");
        issue(mk(32'h144, 32'h00004812, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
                 32'h0, 32'h0), 32'hFFFFFFFD, 32'h4812);
        issue(mk(32'h148, 32'h00004010, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                 32'h0, 32'h0), 32'hFFFFFFFF, 32'h4010);

        // Unsigned divide by zero
        issue(mk(32'h150, 32'h0022001B, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'd5, 32'd0), 32'h0, 32'h20);
        div_cycles("divu0_stall_cycles");
        issue(mk(32'h154, 32'h00004812, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
                 32'h0, 32'h0), 32'hFFFFFFFF, 32'h4812);
        issue(mk(32'h158, 32'h00004010, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                 32'h0, 32'h0), 32'd5, 32'h4010);

        // Reset in the middle of a division discards it and clears HI/LO
        bus.id_to_ex_bus = mk(32'h160, 32'h0022001B, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0,
                              5'd0, 1'b0, 32'd100, 32'd3);
        @(posedge clk); #1;
        bus.id_to_ex_bus = '0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        chk("busy_before_rst", 76'(bus.stallreq_for_ex), 76'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_div_stallreq", 76'(bus.stallreq_for_ex), 76'd0);
        chk("rst_mid_div_mem_bus", bus.ex_to_mem_bus, 76'd0);
        rst = 1'b0;
        issue(mk(32'h164, 32'h00004010, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                 32'h0, 32'h0), 32'h0, 32'h4010);
        issue(mk(32'h168, 32'h00004812, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
                 32'h0, 32'h0), 32'h0, 32'h4812);
        issue(mk(32'h170, 32'h0022001B, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                 32'd9, 32'd4), 32'h0, 32'h24);
        div_cycles("divu94_stall_cycles");
        issue(mk(32'h174, 32'h00004812, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0,
                 32'h0, 32'h0), 32'd2, 32'h4812);
        issue(mk(32'h178, 32'h00004010, 12'h0, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                 32'h0, 32'h0), 32'd1, 32'h4010);

        // Bubble: EX stopped while MEM runs
        issue(mk(32'h200, 32'h00221821, A_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
                 32'd1, 32'd2), 32'd3, 32'h1822);
        bus.id_to_ex_bus = mk(32'h204, 32'hAC22FFFC, A_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0,
                              5'd0, 1'b0, 32'h1000, 32'hAB);
        tb_stall = 6'b000100;
        @(posedge clk); #1;
        chk("bubble_mem_bus", bus.ex_to_mem_bus, 76'd0);
        chk("bubble_sram", 76'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr,
                                bus.data_sram_wdata}), 76'd0);
        chk("bubble_id_bus", 76'(bus.ex_to_id_bus), 76'd0);
        tb_stall = 6'b0;
        bus.id_to_ex_bus = '0;
        @(posedge clk); #1;

        // Hold: EX and MEM both stopped
        issue(mk(32'h210, 32'h00221821, A_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0,
                 32'h10, 32'h20), 32'h30, 32'h1831);
        bus.id_to_ex_bus = mk(32'h214, 32'hAC22FFFC, A_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0,
                              5'd0, 1'b0, 32'h1000, 32'hAB);
        tb_stall = 6'b001100;
        @(posedge clk); #1;
        chk("hold_mem_bus", bus.ex_to_mem_bus,
            {32'h210, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h30});
        chk("hold_sram", 76'({bus.data_sram_en, bus.data_sram_addr, bus.data_sram_wdata}),
            76'({1'b0, 32'h1831, 32'h20}));
        tb_stall = 6'b0;
        bus.id_to_ex_bus = '0;

        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("sb_drain", 76'(exp_q.size()), 76'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
